// File: rtl/sprite_loader.sv
// Streams RGB444 sprite pixels into the gpu sprite BRAM at base+index, gated by wr_allow.
// A short or overlong stream flags err; surplus beats are drained without writing.
module sprite_loader #(
  parameter int unsigned ram_add_width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ram_add_width-1:0] cmd_base,
  input  logic [ram_add_width:0]   cmd_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [11:0]              s_data,
  input  logic                     s_last,
  input  logic                     wr_allow,
  output logic [ram_add_width-1:0] wr_add,
  output logic [11:0]              wr_data,
  output logic                     wr_req,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  localparam logic [ram_add_width:0] LenOne = 1;

  state_e                   state_q, state_d;
  logic [ram_add_width-1:0] base_q, base_d;
  logic [ram_add_width:0]   len_q, len_d;
  logic [ram_add_width:0]   idx_q, idx_d;
  logic [ram_add_width-1:0] wr_add_q, wr_add_d;
  logic [11:0]              wr_data_q, wr_data_d;
  logic                     wr_req_q, wr_req_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     init_q;

  logic cmd_fire, beat_fire, last_idx;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = s_valid & s_ready;
  assign last_idx  = (idx_q == len_q - LenOne);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      wr_req_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      wr_req_q  <= wr_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      init_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    wr_req_d  = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          base_d = cmd_base;
          len_d  = cmd_len;
          idx_d  = '0;
          err_d  = 1'b0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (beat_fire) begin
          wr_req_d  = 1'b1;
          wr_add_d  = base_q + idx_q[ram_add_width-1:0];
          wr_data_d = s_data;
          idx_d     = idx_q + LenOne;
          if (s_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (!last_idx) err_d = 1'b1;
          end else if (last_idx) begin
            // Stream is longer than the command: flag it and swallow the rest.
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (beat_fire && s_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        // Held off while done is high so a completion is never overlapped by a new command.
        cmd_ready = init_q & ~done_q;
        busy      = 1'b0;
      end
      StLoad:  s_ready = wr_allow;
      StDrain: s_ready = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign wr_add  = wr_add_q;
  assign wr_data = wr_data_q;
  assign wr_req  = wr_req_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: driver pushes expected writes/completions,
// an independent monitor pops and compares them as the DUT presents them.
module tb_sprite_loader;
  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_base = '0;
  logic [W:0]    cmd_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [11:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic          wr_allow = 1'b1;
  logic [W-1:0]  wr_add;
  logic [11:0]   wr_data;
  logic          wr_req;
  logic          busy;
  logic          done;
  logic          err;

  sprite_loader #(.ram_add_width(W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wr_allow(wr_allow), .wr_add(wr_add), .wr_data(wr_data), .wr_req(wr_req),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] add; logic [11:0] data;} wr_t;
  typedef struct {logic err; logic with_wr;} dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every done must match the next queued expectation.
  initial begin
    wr_t we;
    dn_t de;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wr_req) begin
          check("wr_expected", 32'(wr_q.size() != 0), 1);
          if (wr_q.size() != 0) begin
            we = wr_q.pop_front();
            check("wr_add", 32'(wr_add), 32'(we.add));
            check("wr_data", 32'(wr_data), 32'(we.data));
          end
        end
        if (done) begin
          check("done_single_cycle", 32'(done_prev), 0);
          check("done_expected", 32'(dn_q.size() != 0), 1);
          if (dn_q.size() != 0) begin
            de = dn_q.pop_front();
            check("err_at_done", 32'(err), 32'(de.err));
            check("done_with_wr", 32'(wr_req), 32'(de.with_wr));
            if (de.with_wr) check("cmd_ready_at_done", 32'(cmd_ready), 0);
          end
        end
        done_prev = done;
      end else begin
        done_prev = 1'b0;
      end
    end
  end

  // mode 0: wr_allow=1; 1: random wr_allow and gaps; 2: wr_allow pattern 1,0,0,1.
  // abort_after >= 0 asserts reset once that many beats have been written.
  task automatic run_cmd(input logic [W-1:0] base, input int len, input int nbeats,
                         input int mode, input int abort_after);
    logic fire;
    int   cyc;
    int   p;
    wr_t  e;
    dn_t  d;
    cmd_base  = base;
    cmd_len   = len[W:0];
    cmd_valid = 1'b1;
    fire = 1'b0;
    cyc  = 0;
    while (!fire) begin
      @(negedge clk);
      fire = cmd_ready;
      if (fire) begin
        d.err     = (len != 0) && (nbeats != len);
        d.with_wr = (len != 0) && (nbeats <= len);
        if (abort_after < 0) dn_q.push_back(d);
      end
      @(posedge clk); #1;
      cyc++;
      if (!fire && cyc > 100) begin
        check("cmd_accept_timeout", 32'(fire), 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b0;
    if (len == 0) begin
      repeat (3) begin
        @(negedge clk);
        check("busy_len0", 32'(busy), 0);
        @(posedge clk); #1;
      end
      return;
    end
    p = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_after) begin
        s_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_wr_req", 32'(wr_req), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_cmd_ready", 32'(cmd_ready), 0);
        check("abort_done", 32'(done), 0);
        wr_q.delete();
        dn_q.delete();
        @(posedge clk); #2;
        reset = 1'b1;
        check("cmd_ready_before_edge", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        check("cmd_ready_after_release", 32'(cmd_ready), 1);
        return;
      end
      if (mode == 1 && $urandom_range(3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = 12'($urandom);
      s_last  = (i == nbeats - 1);
      fire = 1'b0;
      cyc  = 0;
      while (!fire) begin
        case (mode)
          0:       wr_allow = 1'b1;
          2:       wr_allow = (p % 4 == 0) || (p % 4 == 3);
          default: wr_allow = ($urandom_range(9) < 7);
        endcase
        p++;
        @(negedge clk);
        check("s_ready", 32'(s_ready), (i < len) ? 32'(wr_allow) : 1);
        fire = s_ready;
        if (fire && i < len) begin
          e.add  = base + W'(i);
          e.data = s_data;
          wr_q.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
        if (!fire && cyc > 100) begin
          check("beat_accept_timeout", 32'(fire), 1);
          s_valid = 1'b0;
          return;
        end
      end
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    wr_allow = 1'b1;
  endtask

  initial begin
    int len, nb, cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_req", 32'(wr_req), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_wr_add", 32'(wr_add), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    reset = 1'b1;
    #1;
    check("cmd_ready_pre_edge", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    check("cmd_ready_first_edge", 32'(cmd_ready), 1);

    run_cmd(8'h10, 4, 4, 0, -1);
    run_cmd(8'hFE, 4, 4, 0, -1);
    run_cmd(8'h20, 3, 2, 0, -1);
    run_cmd(8'h30, 2, 4, 0, -1);
    run_cmd(8'h50, 6, 6, 2, -1);
    run_cmd(8'h60, 0, 0, 0, -1);
    run_cmd(8'h00, 256, 256, 1, -1);
    run_cmd(8'h40, 8, 8, 0, 2);
    run_cmd(8'h70, 5, 5, 0, -1);

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(12, 1);
      nb  = ($urandom_range(9) < 6) ? len : $urandom_range(14, 1);
      if ($urandom_range(9) == 0) begin
        len = 0;
        nb  = 0;
      end
      run_cmd(W'($urandom), len, nb, 1, -1);
    end

    cyc = 0;
    while ((wr_q.size() != 0 || dn_q.size() != 0) && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 0);
    check("dn_q_drained", 32'(dn_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
